cpu_jtag_debug_sysclk_sync: RTL

Parametrised system-clock-side receiver for the Nios II JTAG debug path. It synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) from the TCK domain and latches the IR on update-IR. On update-DR it captures the shift register into jdo and raises a one-hot per-IR-channel action/no-action request, held under a valid/ready handshake. Overruns are flagged sticky. It sits between the TCK-side debug shifter and the OCI debug/trace/break logic. It generalises the fixed 2-bit-IR, 38-bit, single-pulse sysclk stage to arbitrary IR/data width and back-pressured delivery.

---
 rtl/cpu_jtag_debug_sysclk_sync.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cpu_jtag_debug_sysclk_sync.sv
// Clock-side receiver for JTAG debug update-IR/update-DR strobes with a valid/ready request.
// Define CPU_JTAG_SYSCLK_TIMEOUT_EN to discard requests left pending for TIMEOUT_CYC cycles.
module cpu_jtag_debug_sysclk_sync #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACT_BIT     = 37,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [IR_W-1:0]        ir_in_i,
    input  logic [DATA_W-1:0]      sr_i,
    input  logic                   vs_uir_i,
    input  logic                   vs_udr_i,
    input  logic                   act_ready_i,
    input  logic                   overrun_clr_i,
    output logic [DATA_W-1:0]      jdo_o,
    output logic [IR_W-1:0]        ir_q_o,
    output logic                   act_valid_o,
    output logic [(2**IR_W)-1:0]   take_action_o,
    output logic [(2**IR_W)-1:0]   take_no_action_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);
    localparam int unsigned NumCh = 2**IR_W;

    typedef enum logic {StIdle, StPend} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic                   uir_hist_q, udr_hist_q;
    logic                   uir_rise, udr_rise;
    logic [DATA_W-1:0]      jdo_q, jdo_d;
    logic [IR_W-1:0]        ir_lat_q, ir_lat_d;
    logic [IR_W-1:0]        chan_q, chan_d;
    logic                   act_q, act_d;
    logic                   overrun_q, overrun_d;
    logic                   capture;
    logic                   tmo_hit;
    logic [NumCh-1:0]       onehot;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_hist_q <= 1'b0;
            udr_hist_q <= 1'b0;
            state_q    <= StIdle;
            jdo_q      <= '0;
            ir_lat_q   <= '0;
            chan_q     <= '0;
            act_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_i};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_i};
            uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
            udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            jdo_q      <= jdo_d;
            ir_lat_q   <= ir_lat_d;
            chan_q     <= chan_d;
            act_q      <= act_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        uir_rise  = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
        udr_rise  = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
        ir_lat_d  = uir_rise ? ir_in_i : ir_lat_q;
        state_d   = state_q;
        jdo_d     = jdo_q;
        chan_d    = chan_q;
        act_d     = act_q;
        overrun_d = overrun_clr_i ? 1'b0 : overrun_q;
        capture   = 1'b0;

        case (state_q)
            StIdle: capture = udr_rise;
            StPend: begin
                if (udr_rise && act_ready_i) begin
                    capture = 1'b1;
                end else begin
                    // Overrun set is applied after the clear so it wins in the same cycle.
                    if (udr_rise) overrun_d = 1'b1;
                    if (act_ready_i || tmo_hit) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            jdo_d   = sr_i;
            chan_d  = uir_rise ? ir_in_i : ir_lat_q;
            act_d   = sr_i[ACT_BIT];
            state_d = StPend;
        end
    end

`ifdef CPU_JTAG_SYSCLK_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        timeout_q;

    assign tmo_hit = (state_q == StPend) && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StPend) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            // A same-cycle ready completes the handshake instead of timing out.
            if (tmo_hit && !act_ready_i) begin
                timeout_q <= 1'b1;
            end else if (overrun_clr_i) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = (TIMEOUT_CYC == 0) ? 1'b0 : 1'b0;
`endif

    always_comb begin
        onehot         = '0;
        onehot[chan_q] = 1'b1;
    end

    assign act_valid_o      = (state_q == StPend);
    assign take_action_o    = (act_valid_o && act_q) ? onehot : '0;
    assign take_no_action_o = (act_valid_o && !act_q) ? onehot : '0;
    assign jdo_o            = jdo_q;
    assign ir_q_o           = ir_lat_q;
    assign overrun_o        = overrun_q;

endmodule
